// File: rtl/dma_sched_pkg.sv
// Shared types for the multi-channel DMA scheduler: FSM states, length
// alignment rule and the per-channel descriptor record.
package dma_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    ISSUE,
    WAIT,
    CMPL
  } state_t;

  localparam logic [1:0] LEN_ALIGN = 2'b00;

  // Descriptor fields are sized for the widest supported configuration;
  // the scheduler zero-extends on capture and truncates on issue.
  localparam int DESC_AW = 64;
  localparam int DESC_LW = 64;

  typedef struct packed {
    logic [DESC_AW-1:0] src;
    logic [DESC_AW-1:0] dst;
    logic [DESC_LW-1:0] len;
  } desc_t;

  function automatic logic len_bad(input logic [DESC_LW-1:0] len);
    return (len == '0) || (len[1:0] != LEN_ALIGN);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request starting at rr_ptr,
// wrapping modulo NUM_CH.
module rr_arbiter #(
  parameter int  NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              grant_valid
);

  logic [CH_W-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_ch_sched.sv
// Multi-channel front end for the single-channel DMA engine: one descriptor
// slot per channel, round-robin issue, per-channel completion with reject flag.
module dma_ch_sched
  import dma_sched_pkg::*;
#(
  parameter int  NUM_CH     = 4,
  parameter int  ADDR_WIDTH = 32,
  parameter int  LEN_WIDTH  = 32,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            req_valid,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_src,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_dst,
  input  logic [NUM_CH*LEN_WIDTH-1:0]  req_len,
  output logic                         eng_start,
  output logic [ADDR_WIDTH-1:0]        eng_src,
  output logic [ADDR_WIDTH-1:0]        eng_dst,
  output logic [LEN_WIDTH-1:0]         eng_len,
  input  logic                         eng_done,
  output logic [NUM_CH-1:0]            cmp_valid,
  output logic [NUM_CH-1:0]            cmp_err,
  output logic                         busy,
  output logic [CH_W-1:0]              active_ch
);

  state_t              state;
  desc_t               slots [NUM_CH];
  logic [NUM_CH-1:0]   slot_full;
  logic [NUM_CH-1:0]   accept;
  logic [NUM_CH-1:0]   active_oh;
  logic [CH_W-1:0]     rr_ptr;
  logic                err;

  logic [NUM_CH-1:0]   grant_oh;
  logic [CH_W-1:0]     grant_idx;
  logic                grant_valid;

  assign req_ready = ~slot_full;
  assign accept    = req_valid & ~slot_full;
  assign busy      = (state != IDLE);

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req         (slot_full),
    .rr_ptr      (rr_ptr),
    .grant       (grant_oh),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) slots[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept[i]) begin
          slots[i].src <= DESC_AW'(req_src[i*ADDR_WIDTH +: ADDR_WIDTH]);
          slots[i].dst <= DESC_AW'(req_dst[i*ADDR_WIDTH +: ADDR_WIDTH]);
          slots[i].len <= DESC_LW'(req_len[i*LEN_WIDTH +: LEN_WIDTH]);
        end
      end
    end
  end

  // Completion pulses are launched on the edge that enters CMPL so they are
  // visible during the CMPL cycle; the slot is released on the edge leaving it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      slot_full <= '0;
      rr_ptr    <= '0;
      err       <= 1'b0;
      active_ch <= '0;
      active_oh <= '0;
      eng_start <= 1'b0;
      eng_src   <= '0;
      eng_dst   <= '0;
      eng_len   <= '0;
      cmp_valid <= '0;
      cmp_err   <= '0;
    end else begin
      eng_start <= 1'b0;
      cmp_valid <= '0;
      cmp_err   <= '0;
      slot_full <= slot_full | accept;
      case (state)
        IDLE: begin
          if (|slot_full) state <= ARB;
        end
        ARB: begin
          if (grant_valid) begin
            active_ch <= grant_idx;
            active_oh <= grant_oh;
            if (len_bad(slots[grant_idx].len)) begin
              err       <= 1'b1;
              cmp_valid <= grant_oh;
              cmp_err   <= grant_oh;
              state     <= CMPL;
            end else begin
              state <= ISSUE;
            end
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          eng_src   <= ADDR_WIDTH'(slots[active_ch].src);
          eng_dst   <= ADDR_WIDTH'(slots[active_ch].dst);
          eng_len   <= LEN_WIDTH'(slots[active_ch].len);
          eng_start <= 1'b1;
          state     <= WAIT;
        end
        WAIT: begin
          if (eng_done) begin
            cmp_valid <= active_oh;
            cmp_err   <= {NUM_CH{err}} & active_oh;
            state     <= CMPL;
          end
        end
        CMPL: begin
          slot_full <= (slot_full | accept) & ~active_oh;
          rr_ptr    <= (active_ch == CH_W'(NUM_CH - 1)) ? '0 : active_ch + CH_W'(1);
          err       <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_ch_sched.sv
// Directed + randomized bench for dma_ch_sched against a slot/pointer model.
module tb_dma_ch_sched;

  localparam int NUM_CH = 4;
  localparam int AW     = 32;
  localparam int LW     = 32;
  localparam int CH_W   = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_CH-1:0]     req_valid;
  logic [NUM_CH-1:0]     req_ready;
  logic [NUM_CH*AW-1:0]  req_src;
  logic [NUM_CH*AW-1:0]  req_dst;
  logic [NUM_CH*LW-1:0]  req_len;
  logic                  eng_start;
  logic [AW-1:0]         eng_src;
  logic [AW-1:0]         eng_dst;
  logic [LW-1:0]         eng_len;
  logic                  eng_done;
  logic [NUM_CH-1:0]     cmp_valid;
  logic [NUM_CH-1:0]     cmp_err;
  logic                  busy;
  logic [CH_W-1:0]       active_ch;

  always #5 clk = ~clk;

  dma_ch_sched #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src   (req_src),
    .req_dst   (req_dst),
    .req_len   (req_len),
    .eng_start (eng_start),
    .eng_src   (eng_src),
    .eng_dst   (eng_dst),
    .eng_len   (eng_len),
    .eng_done  (eng_done),
    .cmp_valid (cmp_valid),
    .cmp_err   (cmp_err),
    .busy      (busy),
    .active_ch (active_ch)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int start_cnt    = 0;

  // Reference model: pending descriptors and the next channel to favour.
  bit          m_full [NUM_CH];
  logic [31:0] m_src  [NUM_CH];
  logic [31:0] m_dst  [NUM_CH];
  logic [31:0] m_len  [NUM_CH];
  int          m_rr;

  logic [31:0] d_src [NUM_CH];
  logic [31:0] d_dst [NUM_CH];
  logic [31:0] d_len [NUM_CH];

  always @(posedge clk) if (eng_start === 1'b1) start_cnt++;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick();
    for (int k = 0; k < NUM_CH; k++) begin
      if (m_full[(m_rr + k) % NUM_CH]) return (m_rr + k) % NUM_CH;
    end
    return -1;
  endfunction

  function automatic bit model_bad(input logic [31:0] len);
    return (len == 0) || (len % 4 != 0);
  endfunction

  function automatic int model_pending();
    int n = 0;
    for (int i = 0; i < NUM_CH; i++) if (m_full[i]) n++;
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_CH; i++) m_full[i] = 1'b0;
    m_rr = 0;
  endtask

  task automatic model_retire(input int ch);
    m_full[ch] = 1'b0;
    m_rr = (ch + 1) % NUM_CH;
  endtask

  task automatic apply_stimulus_reset();
    reset     = 1'b0;
    req_valid = '0;
    req_src   = '0;
    req_dst   = '0;
    req_len   = '0;
    eng_done  = 1'b0;
    #12;
    check_output("rst_ready", 64'(req_ready), 64'hF);
    check_output("rst_busy", 64'(busy), 64'h0);
    check_output("rst_start", 64'(eng_start), 64'h0);
    check_output("rst_cmp", 64'(cmp_valid), 64'h0);
    check_output("rst_active", 64'(active_ch), 64'h0);
    reset = 1'b1;
    model_clear();
    tick();
  endtask

  task automatic apply_stimulus_load(input logic [NUM_CH-1:0] mask);
    check_output("load_ready", 64'(req_ready & mask), 64'(mask));
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i]) begin
        req_src[i*AW +: AW] = d_src[i];
        req_dst[i*AW +: AW] = d_dst[i];
        req_len[i*LW +: LW] = d_len[i];
      end
    end
    req_valid = req_valid | mask;
    tick();
    req_valid = req_valid & ~mask;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i]) begin
        m_full[i] = 1'b1;
        m_src[i]  = d_src[i];
        m_dst[i]  = d_dst[i];
        m_len[i]  = d_len[i];
      end
    end
  endtask

  // Waits for the next engine start or reject pulse and checks it against the
  // model; rejects are retired here since the engine never runs for them.
  task automatic issue_next(output int exp_ch, output int got_ch, output int waited, output bit good);
    bit found = 1'b0;
    exp_ch = model_pick();
    if (exp_ch < 0) exp_ch = 0;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      if (eng_start === 1'b1 || cmp_valid !== '0) begin
        found = 1'b1;
        break;
      end
      tick();
      waited++;
    end
    check_output("issue_seen", 64'(found), 64'h1);
    got_ch = int'(active_ch);
    check_output("grant_ch", 64'(active_ch), 64'(exp_ch));
    check_output("busy_active", 64'(busy), 64'h1);
    good = !model_bad(m_len[exp_ch]);
    if (good) begin
      check_output("eng_start", 64'(eng_start), 64'h1);
      check_output("eng_src", 64'(eng_src), 64'(m_src[exp_ch]));
      check_output("eng_dst", 64'(eng_dst), 64'(m_dst[exp_ch]));
      check_output("eng_len", 64'(eng_len), 64'(m_len[exp_ch]));
    end else begin
      check_output("rej_valid", 64'(cmp_valid), 64'd1 << exp_ch);
      check_output("rej_err", 64'(cmp_err), 64'd1 << exp_ch);
      check_output("rej_no_start", 64'(eng_start), 64'h0);
      tick();
      check_output("rej_pulse_end", 64'(cmp_valid), 64'h0);
      check_output("rej_reopen", 64'(req_ready[exp_ch]), 64'h1);
      model_retire(exp_ch);
    end
  endtask

  task automatic check_output_complete(input int ch, input int delay);
    for (int i = 1; i < delay; i++) begin
      check_output("no_early_cmp", 64'(cmp_valid), 64'h0);
      tick();
    end
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check_output("cmp_valid", 64'(cmp_valid), 64'd1 << ch);
    check_output("cmp_err", 64'(cmp_err), 64'h0);
    tick();
    check_output("cmp_pulse_end", 64'(cmp_valid), 64'h0);
    check_output("slot_reopen", 64'(req_ready[ch]), 64'h1);
    model_retire(ch);
  endtask

  initial begin
    int          ch, got, w, snap;
    bit          good;
    logic [3:0]  mask;

    apply_stimulus_reset();

    // Single request on channel 2, including issue latency.
    d_src[2] = 32'h1000; d_dst[2] = 32'h2000; d_len[2] = 32'd16;
    apply_stimulus_load(4'b0100);
    issue_next(ch, got, w, good);
    check_output("start_latency", 64'(w), 64'd3);
    check_output_complete(ch, 5);

    // Pointer now sits on the last channel; only slot 0 is loaded.
    d_src[0] = 32'hA000_0000; d_dst[0] = 32'hB000_0000; d_len[0] = 32'd64;
    apply_stimulus_load(4'b0001);
    issue_next(ch, got, w, good);
    check_output("wrap_grant", 64'(got), 64'd0);
    check_output_complete(ch, 2);

    // Fairness from a fresh pointer.
    apply_stimulus_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      d_src[i] = 32'h100 * (i + 1); d_dst[i] = 32'h8000 + i; d_len[i] = 32'd4;
    end
    apply_stimulus_load(4'b1111);
    for (int j = 0; j < NUM_CH; j++) begin
      issue_next(ch, got, w, good);
      check_output("fair_order", 64'(got), 64'(j));
      check_output_complete(ch, 5);
    end
    apply_stimulus_load(4'b1010);
    issue_next(ch, got, w, good);
    check_output("rr_first", 64'(got), 64'd1);
    check_output_complete(ch, 3);
    issue_next(ch, got, w, good);
    check_output("rr_second", 64'(got), 64'd3);
    check_output_complete(ch, 3);
    apply_stimulus_load(4'b0011);
    for (int j = 0; j < 2; j++) begin
      issue_next(ch, got, w, good);
      check_output("reload_order", 64'(got), 64'(j));
      check_output_complete(ch, 5);
    end

    // Rejected descriptors must never start the engine.
    snap = start_cnt;
    d_len[1] = 32'd0;
    apply_stimulus_load(4'b0010);
    issue_next(ch, got, w, good);
    d_len[1] = 32'd6;
    apply_stimulus_load(4'b0010);
    issue_next(ch, got, w, good);
    tick();
    check_output("rej_start_cnt", 64'(start_cnt), 64'(snap));

    // Overlap: ch0 held valid while its own transfer runs, ch3 loads meanwhile.
    d_src[0] = 32'h0000_4000; d_dst[0] = 32'h0000_5000; d_len[0] = 32'd32;
    apply_stimulus_load(4'b0001);
    issue_next(ch, got, w, good);
    req_src[0 +: AW] = 32'hC0DE_0000;
    req_dst[0 +: AW] = 32'hD0DE_0000;
    req_len[0 +: LW] = 32'd128;
    req_valid[0]     = 1'b1;
    check_output("ovl_busy_slot", 64'(req_ready[0]), 64'h0);
    d_src[3] = 32'h3333_0000; d_dst[3] = 32'h4444_0000; d_len[3] = 32'd8;
    apply_stimulus_load(4'b1000);
    check_output("ovl_still_blocked", 64'(req_ready[0]), 64'h0);
    check_output_complete(ch, 3);
    tick();
    req_valid[0] = 1'b0;
    m_full[0] = 1'b1; m_src[0] = 32'hC0DE_0000; m_dst[0] = 32'hD0DE_0000; m_len[0] = 32'd128;
    check_output("ovl_reaccepted", 64'(req_ready[0]), 64'h0);
    issue_next(ch, got, w, good);
    check_output("ovl_ch3_next", 64'(got), 64'd3);
    check_output_complete(ch, 4);
    issue_next(ch, got, w, good);
    check_output_complete(ch, 4);

    // Asynchronous reset while the engine is running.
    d_src[2] = 32'h1234_5678; d_dst[2] = 32'h8765_4320; d_len[2] = 32'd12;
    apply_stimulus_load(4'b0100);
    issue_next(ch, got, w, good);
    #2 reset = 1'b0;
    #1;
    check_output("arst_ready", 64'(req_ready), 64'hF);
    check_output("arst_start", 64'(eng_start), 64'h0);
    check_output("arst_src", 64'(eng_src), 64'h0);
    check_output("arst_dst", 64'(eng_dst), 64'h0);
    check_output("arst_len", 64'(eng_len), 64'h0);
    check_output("arst_busy", 64'(busy), 64'h0);
    check_output("arst_active", 64'(active_ch), 64'h0);
    #3 reset = 1'b1;
    model_clear();
    tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_output("late_done_cmp", 64'(cmp_valid), 64'h0);
      check_output("late_done_busy", 64'(busy), 64'h0);
      tick();
    end

    // Randomized batches served to completion.
    for (int r = 0; r < 8; r++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NUM_CH; i++) begin
        d_src[i] = $urandom();
        d_dst[i] = $urandom();
        case ($urandom_range(0, 3))
          0:       d_len[i] = 32'd0;
          1:       d_len[i] = ($urandom() & ~32'd3) | 32'($urandom_range(1, 3));
          default: d_len[i] = 32'($urandom_range(1, 1024)) * 32'd4;
        endcase
      end
      apply_stimulus_load(mask);
      for (int n = 0; n < NUM_CH && model_pending() > 0; n++) begin
        issue_next(ch, got, w, good);
        if (good) check_output_complete(ch, $urandom_range(1, 6));
      end
      check_output("rand_drained", 64'(req_ready), 64'hF);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dma_ch_sched.md
Name: dma_ch_sched

Overview:
- Multi-channel scheduler in front of the single-channel DMA engine.
- Holds one pending transfer descriptor (src, dst, len) per requester channel.
- Picks one channel at a time by round-robin and issues its descriptor to the engine's config interface (start/src/dst/length/done).
- Returns a per-channel completion pulse, with an error flag for rejected descriptors.

Parameters:
- NUM_CH, 4, number of requester channels (2..8).
- ADDR_WIDTH, 32, width of the source and destination addresses.
- LEN_WIDTH, 32, width of the byte-length field.
- CH_W, $clog2(NUM_CH), channel index width (derived; not overridden).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_CH  per-channel descriptor valid.
- req_ready  out  NUM_CH  per-channel descriptor slot empty.
- req_src  in  NUM_CH*ADDR_WIDTH  packed source addresses; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_dst  in  NUM_CH*ADDR_WIDTH  packed destination addresses, same packing.
- req_len  in  NUM_CH*LEN_WIDTH  packed byte lengths.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_src  out  ADDR_WIDTH  engine source address.
- eng_dst  out  ADDR_WIDTH  engine destination address.
- eng_len  out  LEN_WIDTH  engine byte length.
- eng_done  in  1  engine completion pulse.
- cmp_valid  out  NUM_CH  one-cycle completion pulse, per channel.
- cmp_err  out  NUM_CH  descriptor rejected; valid only with cmp_valid.
- busy  out  1  scheduler not in IDLE.
- active_ch  out  CH_W  currently granted channel.

Behaviour:
- Reset (reset low, asynchronous): state IDLE, all slots empty, rr_ptr=0.
  - Outputs: req_ready all 1, eng_start 0, eng_src/dst/len 0, cmp_valid 0, cmp_err 0, busy 0, active_ch 0.
  - Reset mid-transfer drops every pending descriptor and produces no completion.
- Slots:
  - req_ready[i] = ~slot_full[i].
  - On req_valid[i] & req_ready[i], capture src/dst/len into slot i; slot_full[i] <= 1.
  - Accepts on any channel proceed in every state, including while another channel is active.
- States: IDLE, ARB, ISSUE, WAIT, CMPL.
  - IDLE: if any slot_full -> ARB, else stay.
  - ARB: grant the first full slot scanning rr_ptr, rr_ptr+1, ... (mod NUM_CH); register it as active_ch.
    - If the granted len==0 or len[1:0]!=0: set err and go to CMPL; the engine is not started.
    - Otherwise -> ISSUE.
  - ISSUE: eng_src/dst/len <= granted slot; eng_start=1 for exactly this cycle -> WAIT.
    - eng_src/dst/len hold their values until the next ISSUE.
  - WAIT: stay until eng_done=1 -> CMPL.
    - eng_done in any other state is ignored.
  - CMPL: cmp_valid[active_ch]=1 and cmp_err[active_ch]=err for exactly this cycle.
    - slot_full[active_ch] <= 0; rr_ptr <= active_ch+1 (wraps to 0 after NUM_CH-1); err <= 0 -> IDLE.
- Latency:
  - Accepted descriptor into an idle scheduler: eng_start 3 cycles after the accept edge.
  - eng_done to cmp_valid: 1 cycle.
  - Channel slot reopens (req_ready high) the cycle after cmp_valid.
- A descriptor arriving in ARB is not considered until the next arbitration.
- Wrap-around: with rr_ptr=NUM_CH-1 and only slot 0 full, slot 0 is granted.
- busy = (state != IDLE); active_ch holds its last grant while IDLE.

Decomposition:
- Package dma_sched_pkg holds:
  - the state_t enum (IDLE, ARB, ISSUE, WAIT, CMPL);
  - the LEN_ALIGN constant (2'b00 check);
  - the channel descriptor struct {src, dst, len}.
- One sub-module, rr_arbiter: NUM_CH request vector plus rr_ptr in, combinational one-hot grant and index out. It is instantiated once; the scheduler registers its output in ARB.

Test Plan:
- Single request: ch2 {src=0x1000, dst=0x2000, len=16} -> eng_start 3 cycles after accept with those values; eng_done -> cmp_valid=4'b0100, cmp_err=0, req_ready[2] high the next cycle.
- Fairness: all 4 channels load with len=4 together; engine returns done 5 cycles after each start -> grant order 0,1,2,3, then a reload of ch0 and ch1 is served 0,1.
- Wrap: after ch3 completes (rr_ptr=0), preload only ch3 and ch1 -> ch1 granted before ch3.
- Reject: ch1 len=0, then ch1 len=6 -> cmp_valid[1]=1 with cmp_err[1]=1 both times; eng_start never asserted.
- Overlap: while ch0 is in WAIT, ch0 req_valid is held -> req_ready[0]=0 and the request is not accepted until after cmp_valid[0]; ch3 is accepted in the same window and issued right after ch0 completes.
- Reset: assert reset during WAIT -> all outputs reach reset values asynchronously; after release, no cmp_valid appears and a late eng_done is ignored.
